// File: rtl/pe_pkg.sv
// Shared types and constants for the int8x4 PE and its controller.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    localparam int PE_WORD_W = 32;
    localparam int PE_ACC_W  = 16;

    // The PE accumulator is 16 bits wide; the upper half of dout carries no information.
    function automatic logic [PE_WORD_W-1:0] sext_acc(input logic [PE_WORD_W-1:0] dout);
        return {{(PE_WORD_W-PE_ACC_W){dout[PE_ACC_W-1]}}, dout[PE_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/pe_ctrl.sv
// Dot-product sequencer: loads B into PE RAM, streams A aligned to the PE read latency,
// counts dvalid pulses and returns the sign-extended accumulator.
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int L_RAM_SIZE = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [L_RAM_SIZE:0]     len,
    input  logic [PE_WORD_W-1:0]    s_b_tdata,
    input  logic                    s_b_tvalid,
    output logic                    s_b_tready,
    input  logic [PE_WORD_W-1:0]    s_a_tdata,
    input  logic                    s_a_tvalid,
    output logic                    s_a_tready,
    output logic                    busy,
    output logic                    done,
    output logic [PE_WORD_W-1:0]    result,
    output logic                    pe_aresetn,
    output logic [PE_WORD_W-1:0]    pe_din,
    output logic [L_RAM_SIZE-1:0]   pe_addr,
    output logic                    pe_we,
    output logic [PE_WORD_W-1:0]    pe_ain,
    output logic                    pe_valid,
    input  logic                    pe_dvalid,
    input  logic [PE_WORD_W-1:0]    pe_dout
);

    localparam int LW = L_RAM_SIZE + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(1 << L_RAM_SIZE);

    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    state_t              state, state_nx;
    logic [LW-1:0]       len_r, k, dv_cnt;
    logic [PE_WORD_W-1:0] a_hold;
    logic                clr_reg;
    logic                b_hs, a_hs, last_b, last_a, dv_hit;

    assign s_b_tready = (state == LOAD);
    assign s_a_tready = (state == COMPUTE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign pe_aresetn = aresetn & ~clr_reg;

    assign b_hs   = s_b_tvalid & s_b_tready;
    assign a_hs   = s_a_tvalid & s_a_tready;
    assign last_b = b_hs && (k == len_r - LW'(1));
    assign last_a = a_hs && (k == len_r - LW'(1));
    assign dv_hit = pe_dvalid && (dv_cnt + LW'(1) == len_r);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : CLEAR;
            CLEAR:   state_nx = LOAD;
            LOAD:    if (last_b) state_nx = COMPUTE;
            COMPUTE: if (last_a) state_nx = DRAIN;
            DRAIN:   if (dv_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            len_r    <= '0;
            k        <= '0;
            dv_cnt   <= '0;
            a_hold   <= '0;
            clr_reg  <= 1'b0;
            result   <= '0;
            pe_din   <= '0;
            pe_addr  <= '0;
            pe_we    <= 1'b0;
            pe_ain   <= '0;
            pe_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;
            clr_reg  <= 1'b0;
            // A data reaches the PE one cycle after its address, matching the RAM read latency
            pe_ain   <= a_hold;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r  <= sat_len(len);
                        k      <= '0;
                        dv_cnt <= '0;
                        if (len == '0) result  <= '0;
                        else           clr_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (b_hs) begin
                        pe_we   <= 1'b1;
                        pe_addr <= k[L_RAM_SIZE-1:0];
                        pe_din  <= s_b_tdata;
                        k       <= last_b ? '0 : k + LW'(1);
                    end
                end
                COMPUTE: begin
                    if (a_hs) begin
                        pe_valid <= 1'b1;
                        pe_addr  <= k[L_RAM_SIZE-1:0];
                        a_hold   <= s_a_tdata;
                        k        <= k + LW'(1);
                    end
                end
                default: ;
            endcase
            if (pe_dvalid && (state == COMPUTE || state == DRAIN))
                dv_cnt <= dv_cnt + LW'(1);
            if (state == DRAIN && dv_hit)
                result <= sext_acc(pe_dout);
        end
    end

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a cycle-level model of the two-stage int8x4 PE.
module tb_pe_ctrl;

    localparam int L = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [L:0]  len = '0;
    logic [31:0] s_b_tdata = '0, s_a_tdata = '0;
    logic        s_b_tvalid = 1'b0, s_a_tvalid = 1'b0;
    logic        s_b_tready, s_a_tready, busy, done;
    logic [31:0] result, pe_din, pe_ain, pe_dout;
    logic        pe_aresetn, pe_we, pe_valid, pe_dvalid;
    logic [L-1:0] pe_addr;

    int n_vec = 0, n_miss = 0;
    int cyc = 0;
    int vcnt, vfirst, vlast;
    logic [31:0] bw [16];
    logic [31:0] aw [16];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    pe_ctrl #(.L_RAM_SIZE(L)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .len(len),
        .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
        .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
        .busy(busy), .done(done), .result(result), .pe_aresetn(pe_aresetn),
        .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we), .pe_ain(pe_ain),
        .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
    );

    // PE model: RAM read 1 cycle, product stage, accumulate stage
    logic [31:0] ram [16];
    logic [31:0] ram_q;
    logic        vld_p0, vld_p1, dv;
    logic [15:0] psum_p1, acc;

    function automatic logic [15:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [17:0] s;
        s = '0;
        for (int i = 0; i < 4; i++)
            s = s + 18'($signed(a[8*i +: 8]) * $signed(b[8*i +: 8]));
        return s[15:0];
    endfunction

    always_ff @(posedge aclk) begin
        if (pe_we) ram[pe_addr] <= pe_din;
        ram_q <= ram[pe_addr];
        if (!pe_aresetn) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            psum_p1 <= '0;
            acc     <= '0;
            dv      <= 1'b0;
        end else begin
            vld_p0 <= pe_valid;
            vld_p1 <= vld_p0;
            if (vld_p0) psum_p1 <= dot4(pe_ain, ram_q);
            if (vld_p1) acc <= acc + psum_p1;
            dv <= vld_p1;
        end
    end
    assign pe_dvalid = dv;
    assign pe_dout   = {16'hDEAD, acc};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (pe_valid) begin
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            vcnt++;
        end
    endtask

    task automatic feed(input bit is_a, input int n, input logic [15:0] pat, input int plen);
        int idx = 0, slot = 0, budget = 0;
        logic v, r;
        while (idx < n && budget < 200) begin
            @(negedge aclk);
            sample();
            v = (slot < plen) ? pat[slot] : 1'b1;
            if (is_a) begin
                s_a_tvalid = v; s_a_tdata = aw[idx]; r = s_a_tready;
            end else begin
                s_b_tvalid = v; s_b_tdata = bw[idx]; r = s_b_tready;
            end
            @(posedge aclk);
            if (v && r) idx++;
            if (slot < plen && (!v || r)) slot++;
            budget++;
        end
        #1;
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        if (idx < n) chk(is_a ? "feed_a_timeout" : "feed_b_timeout", idx, n);
    endtask

    task automatic do_run(input string tag, input int n, input logic [15:0] pat, input int plen,
                          input logic [31:0] exp_res, input int exp_lat);
        int t0, b;
        logic seen;
        vcnt = 0; vfirst = -1; vlast = -1;
        @(negedge aclk);
        start = 1'b1; len = (L+1)'(n);
        @(posedge aclk);
        #1 start = 1'b0;
        t0 = cyc;
        if (n > 0) begin
            feed(1'b0, n, '0, 0);
            feed(1'b1, n, pat, plen);
        end
        seen = 1'b0; b = 0;
        while (!seen && b < 100) begin
            @(negedge aclk);
            sample();
            seen = done;
            b++;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        if (exp_lat >= 0) chk({tag, "_lat"}, cyc - t0, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        @(negedge aclk);
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int seen_done;
        repeat (3) @(negedge aclk);
        chk("rst_ctl", {26'd0, busy, done, s_b_tready, s_a_tready, pe_we, pe_valid}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_pe", {pe_din ^ pe_ain, 28'd0, pe_addr}, 32'd0);
        aresetn = 1'b1;

        // 1: len 4 ones times twos
        for (int i = 0; i < 16; i++) begin bw[i] = 32'h01010101; aw[i] = 32'h02020202; end
        do_run("t1", 4, '0, 0, 32'h00000020, 13);

        // 2: signed lane and sign extension
        bw[0] = 32'h7F000000; aw[0] = 32'hFF000000;
        do_run("t2", 1, '0, 0, 32'hFFFFFF81, 7);

        // 3: full-length wrap
        for (int i = 0; i < 16; i++) begin bw[i] = 32'h7F7F7F7F; aw[i] = 32'h7F7F7F7F; end
        do_run("t3", 16, '0, 0, 32'hFFFFC040, 37);

        // 4: A bubbles 1,0,0,1,0,1
        for (int i = 0; i < 16; i++) begin bw[i] = 32'h01010101; aw[i] = 32'h02020202; end
        do_run("t4", 3, 16'b0000_0000_0010_1001, 6, 32'h00000018, -1);
        chk("t4_vcnt", vcnt, 3);
        chk("t4_vspan", vlast - vfirst, 5);
        do_run("t4ref", 3, '0, 0, 32'h00000018, 11);

        // 5: back-to-back, CLEAR isolates the second run
        do_run("t5a", 4, '0, 0, 32'h00000020, 13);
        bw[0] = 32'h01000000; bw[1] = 32'h01000000;
        aw[0] = 32'h01000000; aw[1] = 32'h01000000;
        do_run("t5b", 2, '0, 0, 32'h00000002, 9);

        // 6: abort mid-COMPUTE, then fresh run and zero-length run
        for (int i = 0; i < 16; i++) begin bw[i] = 32'h01010101; aw[i] = 32'h02020202; end
        @(negedge aclk);
        start = 1'b1; len = 5'd4;
        @(posedge aclk);
        #1 start = 1'b0;
        feed(1'b0, 4, '0, 0);
        feed(1'b1, 2, '0, 0);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        chk("t6_abort", {29'd0, busy, pe_valid, s_a_tready}, 32'd0);
        seen_done = 0;
        repeat (20) begin
            @(negedge aclk);
            if (done) seen_done++;
        end
        chk("t6_nodone", seen_done, 0);
        do_run("t6run", 4, '0, 0, 32'h00000020, 13);
        do_run("t6len0", 0, '0, 0, 32'h00000000, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
